// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: shares one single-port DM between the CPU memory
// stage (fixed high priority) and an external debug/DMA port. A starvation
// counter forces an external grant after STARVE_MAX consecutive lost cycles.
module dm_port_arbiter #(
  parameter int unsigned ADDR_BIT   = 10,
  parameter int unsigned OP_BIT     = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  // CPU memory stage
  input  logic                cpu_req,
  input  logic                cpu_w_en,
  input  logic [OP_BIT-1:0]   cpu_op,
  input  logic [ADDR_BIT-1:0] cpu_addr,
  input  logic [31:0]         cpu_wdata,
  output logic                cpu_stall,
  output logic [31:0]         cpu_rdata,
  // External debug/DMA port
  input  logic                ext_req,
  input  logic                ext_w_en,
  input  logic [OP_BIT-1:0]   ext_op,
  input  logic [ADDR_BIT-1:0] ext_addr,
  input  logic [31:0]         ext_wdata,
  output logic                ext_gnt,
  output logic                ext_rvalid,
  output logic [31:0]         ext_rdata,
  // Data memory
  output logic [OP_BIT-1:0]   mem_op,
  output logic                mem_w_en,
  output logic [ADDR_BIT-1:0] mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  // Statistics
  output logic [15:0]         stall_cnt
);

  localparam int unsigned          CntW      = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0]      StarveMax = CntW'(STARVE_MAX);

  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            ext_rvalid_q, ext_rvalid_d;
  logic [31:0]     ext_rdata_q, ext_rdata_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  logic force_ext;
  logic grant_c;
  logic grant_e;
  logic ext_read;

  // Grant decision: CPU wins unless E has been starved to the limit.
  always_comb begin
    force_ext = ext_req & (starve_cnt_q == StarveMax);
    grant_c   = en & cpu_req & ~force_ext;
    grant_e   = en & ext_req & ~grant_c;
    ext_read  = grant_e & ~ext_w_en;
    cpu_stall = en & cpu_req & ~grant_c;
    ext_gnt   = grant_e;
    cpu_rdata = mem_rdata;
  end

  // Memory mux; CPU fields are the default so a lone CPU access needs no grant logic on the path.
  always_comb begin
    mem_op    = cpu_op;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (grant_e) begin
      mem_op    = ext_op;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
    mem_w_en = (grant_c & cpu_w_en) | (grant_e & ext_w_en);
  end

  // Next-state for counters and the external read-return register; everything holds when !en.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    ext_rvalid_d = ext_rvalid_q;
    ext_rdata_d  = ext_rdata_q;
    stall_cnt_d  = stall_cnt_q;
    if (en) begin
      if (grant_e || !ext_req) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q != StarveMax) begin
        starve_cnt_d = starve_cnt_q + CntW'(1);
      end
      ext_rvalid_d = ext_read;
      if (ext_read) begin
        ext_rdata_d = mem_rdata;
      end
      if (cpu_stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      ext_rvalid_q <= ext_rvalid_d;
      ext_rdata_q  <= ext_rdata_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign ext_rvalid = ext_rvalid_q;
  assign ext_rdata  = ext_rdata_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed scenarios plus randomized traffic, all
// checked against a cycle-level behavioural model and a shadow memory.
module tb_dm_port_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned OW = 2;
  localparam int unsigned SM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          cpu_req = 1'b0, cpu_w_en = 1'b0;
  logic [OW-1:0] cpu_op = '0;
  logic [AW-1:0] cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic          cpu_stall;
  logic [31:0]   cpu_rdata;
  logic          ext_req = 1'b0, ext_w_en = 1'b0;
  logic [OW-1:0] ext_op = '0;
  logic [AW-1:0] ext_addr = '0;
  logic [31:0]   ext_wdata = '0;
  logic          ext_gnt, ext_rvalid;
  logic [31:0]   ext_rdata;
  logic [OW-1:0] mem_op;
  logic          mem_w_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [15:0]   stall_cnt;

  dm_port_arbiter #(.ADDR_BIT(AW), .OP_BIT(OW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .cpu_req(cpu_req), .cpu_w_en(cpu_w_en), .cpu_op(cpu_op), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_w_en(ext_w_en), .ext_op(ext_op), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_op(mem_op), .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT
  logic [31:0] dm [0:(1<<AW)-1];
  assign mem_rdata = dm[mem_addr];
  always @(posedge clk) if (mem_w_en) dm[mem_addr] <= mem_wdata;

  // Reference model state
  logic [31:0] ref_mem [0:(1<<AW)-1];
  int          m_wait;   // consecutive cycles E has been refused
  bit          m_rvalid;
  logic [31:0] m_rdata;
  int          m_stall;
  bit          last_ge;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_gc();
    return en && cpu_req && !(ext_req && m_wait >= SM);
  endfunction

  function automatic bit exp_ge();
    return en && ext_req && !exp_gc();
  endfunction

  // Compare every DUT output against the model for the current (settled) inputs.
  task automatic check_all();
    bit gc, ge, we;
    gc = exp_gc();
    ge = exp_ge();
    we = (gc && cpu_w_en) || (ge && ext_w_en);
    check_eq("ext_gnt", 32'(ext_gnt), 32'(ge));
    check_eq("cpu_stall", 32'(cpu_stall), 32'(en && cpu_req && !gc));
    check_eq("mem_w_en", 32'(mem_w_en), 32'(we));
    check_eq("mem_addr", 32'(mem_addr), 32'(ge ? ext_addr : cpu_addr));
    check_eq("mem_op", 32'(mem_op), 32'(ge ? ext_op : cpu_op));
    if (we) check_eq("mem_wdata", mem_wdata, ge ? ext_wdata : cpu_wdata);
    if (gc && !cpu_w_en) check_eq("cpu_rdata", cpu_rdata, ref_mem[cpu_addr]);
    check_eq("ext_rvalid", 32'(ext_rvalid), 32'(m_rvalid));
    check_eq("ext_rdata", ext_rdata, m_rdata);
    check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stall));
  endtask

  // Advance the model by one clock edge (call with pre-edge inputs).
  task automatic model_edge();
    bit gc, ge;
    gc = exp_gc();
    ge = exp_ge();
    last_ge = ge;
    if (!en) return;
    if (gc && cpu_w_en) ref_mem[cpu_addr] = cpu_wdata;
    if (ge && ext_w_en) ref_mem[ext_addr] = ext_wdata;
    m_rvalid = ge && !ext_w_en;
    if (m_rvalid) m_rdata = ref_mem[ext_addr];
    if (ge || !ext_req) m_wait = 0;
    else if (m_wait < SM) m_wait++;
    if (cpu_req && !gc && m_stall < 65535) m_stall++;
  endtask

  task automatic model_reset();
    m_wait = 0; m_rvalid = 0; m_rdata = '0; m_stall = 0; last_ge = 0;
  endtask

  // Inputs are driven right after a negedge; check, clock, return at next negedge.
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    en = 1'b1; cpu_req = 1'b0; cpu_w_en = 1'b0; ext_req = 1'b0; ext_w_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      dm[i] = 32'(i) * 32'h01010101;
      ref_mem[i] = 32'(i) * 32'h01010101;
    end
    dm[10'h010] = 32'h12345678;
    ref_mem[10'h010] = 32'h12345678;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();

    // Reset then idle
    for (int i = 0; i < 3; i++) tick();

    // CPU load from 0x010, E idle
    cpu_req = 1'b1; cpu_addr = 10'h010; cpu_op = 2'd2;
    #1;
    check_eq("cpu_load_data", cpu_rdata, 32'h12345678);
    check_eq("cpu_load_addr", 32'(mem_addr), 32'h010);
    tick();
    idle_inputs();

    // E write then E read of 0x020 with CPU idle
    ext_req = 1'b1; ext_w_en = 1'b1; ext_addr = 10'h020; ext_wdata = 32'hDEADBEEF; ext_op = 2'd1;
    tick();
    ext_w_en = 1'b0;
    tick();
    ext_req = 1'b0;
    #1;
    check_eq("ext_rd_valid", 32'(ext_rvalid), 32'd1);
    check_eq("ext_rd_data", ext_rdata, 32'hDEADBEEF);
    tick();
    check_eq("ext_rd_pulse_end", 32'(ext_rvalid), 32'd0);
    tick();

    // Continuous contention: C,C,C,C,E repeating
    do_reset();
    idle_inputs();
    cpu_req = 1'b1; cpu_w_en = 1'b1; cpu_addr = 10'h030; cpu_wdata = 32'hC0FFEE00;
    ext_req = 1'b1; ext_w_en = 1'b1; ext_addr = 10'h031; ext_wdata = 32'h0BADF00D;
    for (int i = 0; i < 10; i++) begin
      cpu_wdata = 32'hC0FFEE00 + 32'(i);
      #1;
      check_eq("contend_gnt", 32'(ext_gnt), 32'((i % 5) == 4));
      tick();
    end
    #1;
    check_eq("contend_stall_cnt", 32'(stall_cnt), 32'd2);
    check_eq("cpu_store_last", ref_mem[10'h030], 32'hC0FFEE08);

    // en dropped for 3 cycles with starve count at 3
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("en_low_wen", 32'(mem_w_en), 32'd0);
      tick();
    end
    en = 1'b1;
    #1;
    check_eq("en_back_c", 32'(ext_gnt), 32'd0);
    tick();
    #1;
    check_eq("en_back_e", 32'(ext_gnt), 32'd1);
    tick();

    // Reset pulse right after an E read grant
    idle_inputs();
    tick();
    ext_req = 1'b1; ext_w_en = 1'b0; ext_addr = 10'h020;
    #1;
    check_eq("rst_rd_gnt", 32'(ext_gnt), 32'd1);
    @(posedge clk);
    ext_req = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_rvalid", 32'(ext_rvalid), 32'd0);
    check_eq("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Randomized traffic
    do_reset();
    idle_inputs();
    for (int c = 0; c < 3000; c++) begin
      en       = ($urandom_range(0, 9) != 0);
      cpu_req  = ($urandom_range(0, 9) < 7);
      cpu_w_en = $urandom_range(0, 1) == 1;
      cpu_op   = OW'($urandom_range(0, 3));
      cpu_addr = AW'($urandom_range(0, 63));
      cpu_wdata = $urandom;
      // E fields stay stable until granted
      if (!ext_req || last_ge) begin
        ext_req   = $urandom_range(0, 1) == 1;
        ext_w_en  = $urandom_range(0, 1) == 1;
        ext_op    = OW'($urandom_range(0, 3));
        ext_addr  = AW'($urandom_range(0, 63));
        ext_wdata = $urandom;
      end
      tick();
    end

    // Final memory sweep against the shadow copy
    for (int a = 0; a < 64; a++) check_eq("mem_final", dm[a], ref_mem[a]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
